// File: rtl/audio_play_ctrl.sv
// audio_play_ctrl: playback controller between a stereo sample FIFO and an
// I2S transmitter. Prefetches one sample on start, generates the bit clock
// (sck_bclk) and word clock (ws_lrc), refills the output sample on each
// transmitter request, and drains to a frame boundary on stop.
//
// Optional build macro: AUDIO_UNDERRUN_CNT_EN enables a saturating 16-bit
// underrun counter; when it is undefined, underrun_cnt is tied to zero.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   start, stop      playback request (IDLE only) / stop request
//   fifo_empty       sample FIFO empty flag
//   fifo_rd_en       one-cycle FIFO read strobe
//   fifo_rdata       {left[15:0], right[15:0]}, valid the cycle after the strobe
//   read_data_en     next-sample request pulse from the transmitter
//   sck_bclk, ws_lrc generated bit and word clocks (ws_lrc=1: left)
//   left_data        left sample, left-justified in 32 bits
//   right_data       right sample, left-justified in 32 bits
//   busy             registered (state != IDLE)
//   underrun_cnt     number of requests that found the FIFO empty
//   dbg_state        current FSM state (0 IDLE, 1 PREFETCH, 2 PLAY, 3 DRAIN)
//
// FIFO handshake: fifo_rd_en is asserted for exactly one cycle, only while
// fifo_empty=0; the FIFO presents the word on fifo_rdata during the following
// cycle and this block captures it at the end of that cycle. At most one read
// is ever in flight, so no request is accepted while a capture is pending.
module audio_play_ctrl #(
  parameter int unsigned BCLK_HALF = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [31:0] fifo_rdata,
  input  logic        read_data_en,
  output logic        sck_bclk,
  output logic        ws_lrc,
  output logic [31:0] left_data,
  output logic [31:0] right_data,
  output logic        busy,
  output logic [15:0] underrun_cnt,
  output logic [1:0]  dbg_state
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREFETCH = 2'd1,
    S_PLAY     = 2'd2,
    S_DRAIN    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       rd_pend_q;   // strobe issued last cycle; word is on fifo_rdata now
  logic [7:0] div_cnt_q;
  logic [4:0] fall_cnt_q;
  logic       ws_rose_q;   // ws_lrc rose at the last edge
  logic       underrun;
  logic       clk_run;
  logic       bclk_tick;
  logic       frame_tick;

  assign dbg_state = state_q;

  // Clocks run in PLAY and DRAIN, except on the edge that returns to IDLE.
  assign clk_run    = ((state_q == S_PLAY) || (state_q == S_DRAIN)) && (state_d != S_IDLE);
  assign bclk_tick  = clk_run && (div_cnt_q == DIV_LAST);
  // Every 32nd falling bclk edge flips the word clock.
  assign frame_tick = bclk_tick && sck_bclk && (fall_cnt_q == 5'd31);

  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    underrun   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_PREFETCH;
      end
      S_PREFETCH: begin
        if (stop)                 state_d = S_IDLE;
        else if (rd_pend_q)       state_d = S_PLAY;
        else if (!fifo_empty)     fifo_rd_en = 1'b1;
      end
      S_PLAY: begin
        if (stop) begin
          state_d = S_DRAIN;
        end else if (read_data_en && !rd_pend_q) begin
          if (!fifo_empty) fifo_rd_en = 1'b1;
          else             underrun   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (ws_rose_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy       <= 1'b0;
      rd_pend_q  <= 1'b0;
      left_data  <= '0;
      right_data <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= (state_d != S_IDLE);
      rd_pend_q <= fifo_rd_en;
      if (rd_pend_q) begin
        left_data  <= {fifo_rdata[31:16], 16'h0000};
        right_data <= {fifo_rdata[15:0],  16'h0000};
      end else if (underrun) begin
        left_data  <= '0;
        right_data <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      fall_cnt_q <= '0;
      sck_bclk   <= 1'b0;
      ws_lrc     <= 1'b0;
      ws_rose_q  <= 1'b0;
    end else if (!clk_run) begin
      div_cnt_q  <= '0;
      fall_cnt_q <= '0;
      sck_bclk   <= 1'b0;
      ws_lrc     <= 1'b0;
      ws_rose_q  <= 1'b0;
    end else begin
      ws_rose_q <= frame_tick && !ws_lrc;
      if (bclk_tick) begin
        div_cnt_q <= '0;
        sck_bclk  <= ~sck_bclk;
        if (sck_bclk) begin
          if (fall_cnt_q == 5'd31) begin
            fall_cnt_q <= '0;
            ws_lrc     <= ~ws_lrc;
          end else begin
            fall_cnt_q <= fall_cnt_q + 5'd1;
          end
        end
      end else begin
        div_cnt_q <= div_cnt_q + 8'd1;
      end
    end
  end

`ifdef AUDIO_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                underrun_cnt <= '0;
    else if (underrun && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
  end
`else
  assign underrun_cnt = 16'h0000;
`endif

endmodule

// File: doc/audio_play_ctrl.md
AUDIO_PLAY_CTRL -- requirements
Module: audio_play_ctrl

Interface
REQ-001 The block SHALL have parameter BCLK_HALF, default 4: clk cycles per sck_bclk half-period, legal range 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; every register is clocked on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: playback request, sampled only in IDLE.
REQ-005 The block SHALL have port stop, input, 1 bit: stop request, sampled only in PREFETCH and PLAY.
REQ-006 The block SHALL have port fifo_empty, input, 1 bit: sample FIFO empty flag.
REQ-007 The block SHALL have port fifo_rd_en, output, 1 bit: single-cycle FIFO read strobe.
REQ-008 The block SHALL have port fifo_rdata, input, 32 bits: [31:16] is the left sample and [15:0] the right sample; data is valid 1 cycle after fifo_rd_en.
REQ-009 The block SHALL have port read_data_en, input, 1 bit: next-sample request pulse from the I2S transmitter.
REQ-010 The block SHALL have port sck_bclk, output, 1 bit: generated bit clock.
REQ-011 The block SHALL have port ws_lrc, output, 1 bit: generated word clock; 1 = left channel.
REQ-012 The block SHALL have port left_data, output, 32 bits: left sample, left-justified.
REQ-013 The block SHALL have port right_data, output, 32 bits: right sample, left-justified.
REQ-014 The block SHALL have port busy, output, 1 bit: 1 whenever state is not IDLE.
REQ-015 The block SHALL have port underrun_cnt, output, 16 bits: count of missed samples.

Function
REQ-016 The block SHALL implement the states IDLE, PREFETCH, PLAY and DRAIN, held in a registered state machine.
REQ-017 IDLE: the block SHALL hold sck_bclk=0 and ws_lrc=0 and hold the clock-divider counters at 0; start=1 SHALL move the state to PREFETCH.
REQ-018 PREFETCH, when fifo_empty=0: the block SHALL pulse fifo_rd_en for 1 cycle, latch fifo_rdata 1 cycle later, and enter PLAY on the cycle the data is latched.
REQ-019 PREFETCH, when fifo_empty=1: the block SHALL wait indefinitely, and stop=1 SHALL return the state to IDLE.
REQ-020 Sample expansion: the block SHALL drive left_data={fifo_rdata[31:16],16'h0000} and right_data={fifo_rdata[15:0],16'h0000}, updated only on the latch cycle.
REQ-021 PLAY: sck_bclk SHALL toggle every BCLK_HALF clk cycles, starting with a rising edge BCLK_HALF cycles after PLAY entry.
REQ-022 ws_lrc SHALL toggle coincident with every 32nd sck_bclk falling edge, giving 64 bclk per frame; its first rise SHALL occur at the 32nd falling edge after PLAY entry.
REQ-023 read_data_en=1 in PLAY with fifo_empty=0: the block SHALL pulse fifo_rd_en for 1 cycle and latch the sample 1 cycle later (latency 2 clk from request to new data).
REQ-024 read_data_en=1 in PLAY with fifo_empty=1 (underrun): the block SHALL assert no read, set left_data and right_data to 0 on the next cycle, and increment underrun_cnt.
REQ-025 The block SHALL never have more than one FIFO read outstanding; read_data_en arriving while a latch is pending SHALL be ignored.
REQ-026 stop=1 in PLAY SHALL move the state to DRAIN; clocks SHALL continue until the next ws_lrc rising edge, then the state SHALL enter IDLE with both clocks 0 and no further FIFO read.
REQ-027 The block SHALL issue no FIFO reads in DRAIN; read_data_en in DRAIN SHALL be ignored.
REQ-028 start and stop both 1 in the same cycle: stop SHALL take priority in PREFETCH and PLAY; start SHALL be ignored outside IDLE.
REQ-029 busy SHALL be a registered decode of state != IDLE.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state=IDLE and all outputs to 0, including underrun_cnt, left_data, right_data, sck_bclk and ws_lrc.
REQ-031 Reset asserted mid-frame SHALL abort immediately; after release the block SHALL stay in IDLE until a new start.

Configuration
REQ-032 With the macro AUDIO_UNDERRUN_CNT_EN defined, underrun_cnt SHALL increment once per underrun and saturate at 16'hFFFF; it SHALL clear only on reset.
REQ-033 Without AUDIO_UNDERRUN_CNT_EN, underrun_cnt SHALL be tied to 16'h0000 and no counter logic SHALL be built; all other behaviour SHALL be unchanged.

Verification
REQ-034 Scenario, basic playback: BCLK_HALF=4, FIFO preloaded with 32'h1234_ABCD, start pulse -> fifo_rd_en 1 cycle; left_data=32'h1234_0000 and right_data=32'hABCD_0000; sck_bclk period 8 clk; ws_lrc period 512 clk.
REQ-035 Scenario, underrun: empty FIFO during read_data_en in PLAY -> fifo_rd_en stays 0; both data outputs 0 next cycle; underrun_cnt=1 with AUDIO_UNDERRUN_CNT_EN defined, 0 without it.
REQ-036 Scenario, stop mid-frame: stop pulse 100 clk after a ws_lrc rise -> clocks continue until the next ws_lrc rise, then busy=0 and sck_bclk=ws_lrc=0, with no fifo_rd_en in DRAIN.
REQ-037 Scenario, simultaneous start and stop in IDLE -> PREFETCH; start and stop together in PREFETCH with empty FIFO -> IDLE next cycle.
REQ-038 Scenario, reset mid-PLAY: rst_n low for 3 clk -> all outputs 0 immediately; block stays in IDLE after release with no FIFO reads.
REQ-039 Scenario, saturation: force 65 540 underruns with AUDIO_UNDERRUN_CNT_EN defined -> underrun_cnt holds 16'hFFFF.
